// File: rtl/sr_ff_checker.sv
// Self-checking monitor for an SR flip-flop: tracks the expected Q from S/R,
// flags mismatches and S=R=1 stimulus, and keeps saturating check statistics.
module sr_ff_checker #(
  parameter int CW          = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_s,
  input  logic          i_r,
  input  logic          i_q,
  output logic          o_err,
  output logic          o_mismatch,
  output logic          o_illegal,
  output logic [CW-1:0] o_err_cnt,
  output logic [CW-1:0] o_ill_cnt,
  output logic [CW-1:0] o_chk_cnt,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'b00,
    ST_TRACK  = 2'b01,
    ST_FAIL   = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  state_t        r_state, w_state;
  logic          r_exp, w_exp;
  logic          r_valid, w_valid;
  logic          r_err, w_err;
  logic          r_mismatch, w_mismatch;
  logic          r_illegal, w_illegal;
  logic [CW-1:0] r_err_cnt, w_err_cnt;
  logic [CW-1:0] r_ill_cnt, w_ill_cnt;
  logic [CW-1:0] r_chk_cnt, w_chk_cnt;
  logic          w_stop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_TRACK;
      r_exp      <= 1'b0;
      r_valid    <= 1'b1;
      r_err      <= 1'b0;
      r_mismatch <= 1'b0;
      r_illegal  <= 1'b0;
      r_err_cnt  <= '0;
      r_ill_cnt  <= '0;
      r_chk_cnt  <= '0;
    end else begin
      r_state    <= w_state;
      r_exp      <= w_exp;
      r_valid    <= w_valid;
      r_err      <= w_err;
      r_mismatch <= w_mismatch;
      r_illegal  <= w_illegal;
      r_err_cnt  <= w_err_cnt;
      r_ill_cnt  <= w_ill_cnt;
      r_chk_cnt  <= w_chk_cnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_exp      = r_exp;
    w_valid    = r_valid;
    w_err      = r_err;
    w_mismatch = 1'b0;
    w_illegal  = 1'b0;
    w_err_cnt  = r_err_cnt;
    w_ill_cnt  = r_ill_cnt;
    w_chk_cnt  = r_chk_cnt;
    w_stop     = 1'b0;

    // The model follows S/R in every state, including FAIL and with EN low.
    case ({i_s, i_r})
      2'b10: begin w_exp = 1'b1; w_valid = 1'b1; end
      2'b01: begin w_exp = 1'b0; w_valid = 1'b1; end
      2'b11: w_valid = 1'b0;
      default: ;
    endcase

    if (i_clr) begin
      w_err     = 1'b0;
      w_err_cnt = '0;
      w_ill_cnt = '0;
      w_chk_cnt = '0;
      w_state   = w_valid ? ST_TRACK : ST_UNSYNC;
    end else if (r_state != ST_FAIL) begin
      // Q at this edge answers the S/R seen at the previous edge, i.e. r_exp.
      if (r_state == ST_TRACK && i_en) begin
        w_chk_cnt = sat_inc(r_chk_cnt);
        if (i_q != r_exp) begin
          w_mismatch = 1'b1;
          w_err      = 1'b1;
          w_err_cnt  = sat_inc(r_err_cnt);
          w_stop     = STOP_ON_ERR;
        end
      end
      if (i_s && i_r) begin
        w_state = ST_UNSYNC;
        if (i_en) begin
          w_illegal = 1'b1;
          w_ill_cnt = sat_inc(r_ill_cnt);
        end
      end else if (r_state == ST_UNSYNC && (i_s ^ i_r)) begin
        w_state = ST_TRACK;
      end
      if (w_stop) begin
        w_state = ST_FAIL;
      end
    end
  end

  assign o_err      = r_err;
  assign o_mismatch = r_mismatch;
  assign o_illegal  = r_illegal;
  assign o_err_cnt  = r_err_cnt;
  assign o_ill_cnt  = r_ill_cnt;
  assign o_chk_cnt  = r_chk_cnt;
  assign o_state    = r_state;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: three instances (CW=8 free-running, CW=8 stop-on-error,
// CW=4 free-running) share one stimulus stream and are checked against a rule model.
module tb_sr_ff_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, clr = 1'b0, s = 1'b0, r = 1'b0, q = 1'b0;

  always #5 clk = ~clk;

  logic       d_err [3];
  logic       d_mis [3];
  logic       d_ill [3];
  logic [7:0] d_ec  [3];
  logic [7:0] d_ic  [3];
  logic [7:0] d_cc  [3];
  logic [1:0] d_st  [3];
  logic [3:0] c_ec, c_ic, c_cc;

  sr_ff_checker #(.CW(8), .STOP_ON_ERR(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_s(s), .i_r(r), .i_q(q),
    .o_err(d_err[0]), .o_mismatch(d_mis[0]), .o_illegal(d_ill[0]),
    .o_err_cnt(d_ec[0]), .o_ill_cnt(d_ic[0]), .o_chk_cnt(d_cc[0]), .o_state(d_st[0]));

  sr_ff_checker #(.CW(8), .STOP_ON_ERR(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_s(s), .i_r(r), .i_q(q),
    .o_err(d_err[1]), .o_mismatch(d_mis[1]), .o_illegal(d_ill[1]),
    .o_err_cnt(d_ec[1]), .o_ill_cnt(d_ic[1]), .o_chk_cnt(d_cc[1]), .o_state(d_st[1]));

  sr_ff_checker #(.CW(4), .STOP_ON_ERR(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_s(s), .i_r(r), .i_q(q),
    .o_err(d_err[2]), .o_mismatch(d_mis[2]), .o_illegal(d_ill[2]),
    .o_err_cnt(c_ec), .o_ill_cnt(c_ic), .o_chk_cnt(c_cc), .o_state(d_st[2]));

  assign d_ec[2] = {4'b0000, c_ec};
  assign d_ic[2] = {4'b0000, c_ic};
  assign d_cc[2] = {4'b0000, c_cc};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Rule model: state 0=UNSYNC 1=TRACK 2=FAIL, plain integers throughout.
  int m_max  [3] = '{255, 255, 15};
  bit m_stop [3] = '{1'b0, 1'b1, 1'b0};
  int m_exp [3], m_valid [3], m_state [3];
  int m_err [3], m_mis [3], m_ill [3], m_ec [3], m_ic [3], m_cc [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_exp[i] = 0; m_valid[i] = 1; m_state[i] = 1;
        m_err[i] = 0; m_mis[i] = 0; m_ill[i] = 0;
        m_ec[i] = 0; m_ic[i] = 0; m_cc[i] = 0;
      end else begin
        int nexp, nvalid, ns;
        nexp = m_exp[i]; nvalid = m_valid[i];
        if (s && !r) begin nexp = 1; nvalid = 1; end
        if (!s && r) begin nexp = 0; nvalid = 1; end
        if (s && r) nvalid = 0;
        m_mis[i] = 0;
        m_ill[i] = 0;
        if (clr) begin
          m_ec[i] = 0; m_ic[i] = 0; m_cc[i] = 0; m_err[i] = 0;
          m_state[i] = nvalid ? 1 : 0;
        end else if (m_state[i] != 2) begin
          ns = m_state[i];
          if (m_state[i] == 1 && en) begin
            m_cc[i] = (m_cc[i] + 1 > m_max[i]) ? m_max[i] : m_cc[i] + 1;
            if (int'(q) != m_exp[i]) begin
              m_mis[i] = 1;
              m_err[i] = 1;
              m_ec[i]  = (m_ec[i] + 1 > m_max[i]) ? m_max[i] : m_ec[i] + 1;
            end
          end
          if (s && r) begin
            ns = 0;
            if (en) begin
              m_ill[i] = 1;
              m_ic[i]  = (m_ic[i] + 1 > m_max[i]) ? m_max[i] : m_ic[i] + 1;
            end
          end else if (m_state[i] == 0 && s != r) begin
            ns = 1;
          end
          if (m_mis[i] == 1 && m_stop[i]) ns = 2;
          m_state[i] = ns;
        end
        m_exp[i] = nexp;
        m_valid[i] = nvalid;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 8) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d err", i),      int'(d_err[i]), m_err[i]);
        check($sformatf("dut%0d mismatch", i), int'(d_mis[i]), m_mis[i]);
        check($sformatf("dut%0d illegal", i),  int'(d_ill[i]), m_ill[i]);
        check($sformatf("dut%0d err_cnt", i),  int'(d_ec[i]),  m_ec[i]);
        check($sformatf("dut%0d ill_cnt", i),  int'(d_ic[i]),  m_ic[i]);
        check($sformatf("dut%0d chk_cnt", i),  int'(d_cc[i]),  m_cc[i]);
        check($sformatf("dut%0d state", i),    int'(d_st[i]),  m_state[i]);
      end
    end
  end

  int n_tick = 0;

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input bit ts, input bit tr, input bit tq, input bit ten, input bit tclr);
    s = ts; r = tr; q = tq; en = ten; clr = tclr;
    @(posedge clk);
    @(negedge clk);
    n_tick++;
    $display("tick %0d: S=%0b R=%0b Q=%0b EN=%0b CLR=%0b -> A st=%0d chk=%0d err=%0d | B st=%0d err=%0d | C chk=%0d err=%0d",
             n_tick, ts, tr, tq, ten, tclr, d_st[0], d_cc[0], d_ec[0], d_st[1], d_ec[1], d_cc[2], d_ec[2]);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset state A", int'(d_st[0]), 1);
    check("reset chk_cnt A", int'(d_cc[0]), 0);
    check("reset err A", int'(d_err[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    // Baseline: five passing compares against exp=0.
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
    check("baseline chk_cnt", int'(d_cc[0]), 5);
    check("baseline err_cnt", int'(d_ec[0]), 0);
    check("baseline state", int'(d_st[0]), 1);

    // Set, then Q follows; reset, then Q stays 1 one edge late -> mismatch.
    tick(1, 0, 0, 1, 0);
    tick(0, 0, 1, 1, 0);
    check("set follow no mismatch", int'(d_mis[0]), 0);
    tick(0, 1, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    check("stale Q mismatch", int'(d_mis[0]), 1);
    check("stale Q err_cnt", int'(d_ec[0]), 1);
    check("stale Q err", int'(d_err[0]), 1);
    check("stale Q chk_cnt", int'(d_cc[0]), 9);
    check("stop B state FAIL", int'(d_st[1]), 2);

    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, 0);
    check("stop B err_cnt frozen", int'(d_ec[1]), 1);
    check("free A err_cnt", int'(d_ec[0]), 5);
    tick(0, 0, 0, 1, 0);
    check("mismatch pulse ends", int'(d_mis[0]), 0);
    check("FAIL holds", int'(d_st[1]), 2);

    tick(0, 0, 0, 1, 1);
    check("clr B state", int'(d_st[1]), 1);
    check("clr B err_cnt", int'(d_ec[1]), 0);
    check("clr B err", int'(d_err[1]), 0);
    check("clr A chk_cnt", int'(d_cc[0]), 0);

    // Illegal stimulus and recovery.
    tick(1, 1, 0, 1, 0);
    check("illegal pulse", int'(d_ill[0]), 1);
    check("illegal count", int'(d_ic[0]), 1);
    check("illegal state", int'(d_st[0]), 0);
    check("illegal edge chk_cnt", int'(d_cc[0]), 1);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 1, 1, 0);
    check("unsync chk_cnt frozen", int'(d_cc[0]), 1);
    check("unsync no mismatch", int'(d_mis[0]), 0);
    tick(0, 1, 1, 1, 0);
    check("resync state", int'(d_st[0]), 1);
    tick(0, 0, 0, 1, 0);
    check("resync compare chk_cnt", int'(d_cc[0]), 2);
    check("resync compare passes", int'(d_mis[0]), 0);

    // Saturation on the CW=4 instance.
    for (int i = 0; i < 20; i++) tick(0, 0, 1, 1, 0);
    check("sat C err_cnt", int'(d_ec[2]), 15);
    check("sat C chk_cnt", int'(d_cc[2]), 15);
    check("A err_cnt 20", int'(d_ec[0]), 20);

    // EN low: model keeps tracking, statistics frozen.
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    check("en0 chk_cnt frozen", int'(d_cc[0]), 22);
    check("en0 err_cnt frozen", int'(d_ec[0]), 20);
    tick(0, 0, 1, 1, 0);
    check("en1 resumes pass", int'(d_mis[0]), 0);
    check("en1 chk_cnt", int'(d_cc[0]), 23);
    tick(0, 0, 0, 1, 0);
    check("en1 resumes mismatch", int'(d_mis[0]), 1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async rst err", int'(d_err[0]), 0);
    check("async rst err_cnt", int'(d_ec[0]), 0);
    check("async rst mismatch", int'(d_mis[0]), 0);
    check("async rst state", int'(d_st[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 1, 1, 0);
    check("post-reset compares vs 0", int'(d_mis[0]), 1);
    check("post-reset chk_cnt", int'(d_cc[0]), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_ff_checker.md
# sr_ff_checker

Synthesizable self-checking monitor for the team's SR flip-flop. It is the observing end of the SR flip-flop interface. It samples the same S/R stimulus the flip-flop receives, plus the flip-flop's Q output. It keeps a cycle-accurate reference model of Q and reports mismatches, illegal S=R=1 stimulus, and running check statistics. It sits beside any SR_FF instance, in simulation benches or on-chip as a built-in self-check.

## Interface
- CW, default 8: width of each statistics counter.
- STOP_ON_ERR, default 0: when 1, the first mismatch enters FAIL and freezes checking.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- RST  input  1  asynchronous, active-high reset; resets the checker and is also the reset applied to the observed flip-flop.
- EN  input  1  gates comparisons and counting. The model tracks S/R regardless of EN.
- CLR  input  1  synchronous clear of counters, ERR and FAIL.
- S  input  1  set input, as applied to the flip-flop.
- R  input  1  reset input, as applied to the flip-flop.
- Q  input  1  flip-flop output under check.
- ERR  output  1  sticky error flag.
- MISMATCH  output  1  one-cycle pulse on a failed comparison.
- ILLEGAL  output  1  one-cycle pulse when S=R=1 is sampled with EN=1.
- ERR_CNT  output  CW  saturating mismatch count.
- ILL_CNT  output  CW  saturating illegal-stimulus count.
- CHK_CNT  output  CW  saturating count of comparisons performed.
- STATE  output  2  encoding: 00 UNSYNC, 01 TRACK, 10 FAIL.

## Operation
Observed flip-flop semantics:
- S R = 10 gives Q=1; 01 gives Q=0; 00 holds Q.
- 11 is illegal, and Q is unconstrained afterwards.
- RST forces Q=0.

Internal model:
- Expected register `exp` and a valid bit.
- Every edge, from S/R: 10 sets exp=1 and valid=1; 01 sets exp=0 and valid=1; 00 holds; 11 sets valid=0.

FSM, evaluated each rising edge with the following priority:
1. CLR=1:
   - ERR_CNT, ILL_CNT, CHK_CNT and ERR go to 0.
   - MISMATCH and ILLEGAL are 0 that cycle.
   - Next state is TRACK if the post-update model is valid, otherwise UNSYNC.
   - The model still updates from S/R.
2. FAIL:
   - No compares; counters and ERR frozen.
   - The model still tracks S/R.
   - Exit only via CLR or RST.
3. TRACK with EN=1:
   - Compare Q against the pre-update exp.
   - CHK_CNT++.
   - On inequality: MISMATCH=1, ERR_CNT++, ERR=1. If STOP_ON_ERR=1, next state is FAIL.
4. UNSYNC: no compares and no CHK_CNT change.
5. Stimulus, any state other than FAIL:
   - S=R=1 moves the state to UNSYNC.
   - ILLEGAL=1 and ILL_CNT++ occur only if EN=1.
   - S R = 10 or 01 sampled in UNSYNC moves the state to TRACK; comparison begins at the next edge.
6. TRACK + mismatch (with STOP_ON_ERR=1) + S=R=1 in the same cycle: FAIL wins, and ILLEGAL is still pulsed/counted.

Width and arithmetic rules:
- All counters saturate at 2^CW−1 and never wrap.
- ERR stays 1 until CLR or RST.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - STATE=01 (TRACK); exp=0 and valid=1.
  - ERR, MISMATCH, ILLEGAL = 0; all counters = 0.
- Compare timing: Q sampled at edge k+1 is checked against the S/R sampled at edge k. This matches the flip-flop's one-edge latency.
- Output timing:
  - All outputs are registered.
  - MISMATCH and ILLEGAL are high for exactly the one cycle following the detecting edge.
  - Counters and ERR reflect an event one cycle after the detecting edge.
- After RST deasserts, the first edge compares Q against 0.
- RST asserted mid-operation (including in FAIL) overrides everything asynchronously.
- EN=0 for any number of cycles causes no loss of model sync. Compares resume on the first edge with EN=1.

## Test plan
- **Reset baseline:** RST pulse, then S=R=0 for 5 edges with Q=0 → CHK_CNT=5, ERR_CNT=0, ERR=0, STATE=01.
- **Set/reset tracking and mismatch detection:**
  - S=1,R=0 for one edge, then Q=1 on the next edge → no MISMATCH.
  - S=0,R=1 for one edge, then Q held 1 on the next edge → MISMATCH pulses one cycle, ERR_CNT=1, ERR=1.
- **Illegal stimulus recovery:**
  - S=R=1 → ILLEGAL pulse, ILL_CNT=1, STATE=00.
  - Q toggled randomly for 3 edges → CHK_CNT unchanged, no MISMATCH.
  - S=0,R=1 → STATE=01; Q=0 on the next edge passes.
- **STOP_ON_ERR=1 latch and clear:**
  - A forced mismatch → STATE=10.
  - 4 further wrong Q values → ERR_CNT stays 1.
  - CLR for one edge → all counters 0, ERR=0, STATE=01.
- **Saturation and EN gating:**
  - CW=4, 20 consecutive mismatches → ERR_CNT=15, CHK_CNT=15.
  - EN=0 while S/R change → counters frozen.
  - EN=1 again → compares resume against the correctly tracked exp.
- **Asynchronous reset mid-run:** RST asserted between clock edges while ERR=1 → ERR, counters and pulses go to 0 and STATE=01 before the next CLK edge.
